// File: rtl/ohc11_add_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ohc11_add_scheduler: round-robin share of one mod-11 one-hot residue adder.
// Optional macro OHC11_SUB_EN adds req_sub (per-requester subtract).  Rev 1.0
// ---------------------------------------------------------------------------
module ohc11_add_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [4*NREQ-1:0]   req_a,
  input  logic [4*NREQ-1:0]   req_b,
`ifdef OHC11_SUB_EN
  input  logic [NREQ-1:0]     req_sub,
`endif
  output logic                res_valid,
  input  logic                res_ready,
  output logic [10:0]         res_ohc,
  output logic [3:0]          res_bin,
  output logic [IDW-1:0]      res_id,
  output logic                res_err
);

  logic [IDW-1:0] rr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_any;
  logic           slot_free;
  logic [3:0]     op_a;
  logic [3:0]     op_b;
  logic           op_sub;
  logic           illegal;
  logic [10:0]    oa;
  logic [21:0]    dbl;
  logic [10:0]    sum_ohc;
  logic [3:0]     sum_bin;

  assign slot_free = !res_valid || res_ready;

  // Round-robin search starting at rr, wrapping modulo NREQ.
  always_comb begin : arb
    int             idx;
    logic [IDW-1:0] cand;
    idx       = 0;
    cand      = '0;
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    if (rst_n && slot_free) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        cand = IDW'(idx);
        if (!gnt_any && req_valid[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin : opmux
    op_a   = '0;
    op_b   = '0;
    op_sub = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt_idx) begin
        op_a = req_a[4*i +: 4];
        op_b = req_b[4*i +: 4];
`ifdef OHC11_SUB_EN
        op_sub = req_sub[i];
`endif
      end
    end
  end

  // Rotation within 11 bits: shift a doubled copy and keep the wrapping half.
  assign illegal = (op_a > 4'd10) || (op_b > 4'd10);
  assign oa      = 11'b1 << op_a;
  assign dbl     = op_sub ? ({oa, oa} >> op_b) : ({oa, oa} << op_b);
  assign sum_ohc = op_sub ? dbl[10:0] : dbl[21:11];

  always_comb begin : enc
    sum_bin = '0;
    for (int k = 0; k < 11; k++) begin
      if (sum_ohc[k]) sum_bin = 4'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_ohc   <= '0;
      res_bin   <= '0;
      res_id    <= '0;
      res_err   <= 1'b0;
      rr        <= '0;
    end else if (gnt_any) begin
      res_valid <= 1'b1;
      res_id    <= gnt_idx;
      res_err   <= illegal;
      res_ohc   <= illegal ? 11'd0 : sum_ohc;
      res_bin   <= illegal ? 4'hF : sum_bin;
      rr        <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ohc11_add_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ohc11_add_scheduler: directed + random bench with residue-arithmetic model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ohc11_add_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a;
  logic [4*NREQ-1:0] req_b;
`ifdef OHC11_SUB_EN
  logic [NREQ-1:0]   req_sub;
`endif
  logic              res_valid;
  logic              res_ready;
  logic [10:0]       res_ohc;
  logic [3:0]        res_bin;
  logic [IDW-1:0]    res_id;
  logic              res_err;

  ohc11_add_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef OHC11_SUB_EN
    .req_sub   (req_sub),
`endif
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ohc   (res_ohc),
    .res_bin   (res_bin),
    .res_id    (res_id),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          m_rr;
  bit          m_valid;
  bit          m_rst;
  bit          m_err;
  int          m_bin;
  int          m_id;
  logic [10:0] m_ohc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b, input bit sub);
    req_a[4*i +: 4] = 4'(a);
    req_b[4*i +: 4] = 4'(b);
`ifdef OHC11_SUB_EN
    req_sub[i] = sub;
`else
    if (sub) $display("note: subtract requested without OHC11_SUB_EN");
`endif
  endtask

  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (m_valid && !res_ready) return -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock: check grant before the edge, update the model, check outputs after.
  task automatic cycle(input bit clr);
    int g, a, b, s;
    bit sub;
    g = exp_grant();
    #1;
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    @(posedge clk);
    m_rst = 1'b0;
    if (!rst_n) begin
      m_valid = 0; m_ohc = '0; m_bin = 0; m_id = 0; m_err = 0; m_rr = 0; m_rst = 1'b1;
    end else if (g >= 0) begin
      a   = int'(4'(req_a >> (4 * g)));
      b   = int'(4'(req_b >> (4 * g)));
      sub = 1'b0;
`ifdef OHC11_SUB_EN
      sub = req_sub[g];
`endif
      m_valid = 1; m_id = g; m_rr = (g + 1) % NREQ;
      if (a > 10 || b > 10) begin
        m_err = 1; m_bin = 15; m_ohc = '0;
      end else begin
        s = sub ? (a - b + 11) % 11 : (a + b) % 11;
        m_err = 0; m_bin = s; m_ohc = 11'(1) << s;
      end
    end else if (res_ready) begin
      m_valid = 0;
    end
    #1;
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    if (m_valid || m_rst) begin
      chk("res_ohc", 32'(res_ohc), 32'(m_ohc));
      chk("res_bin", 32'(res_bin), 32'(m_bin));
      chk("res_id",  32'(res_id),  32'(m_id));
      chk("res_err", 32'(res_err), 32'(m_err));
    end
    if (clr && g >= 0) req_valid[g] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
`ifdef OHC11_SUB_EN
    req_sub = '0;
`endif
    m_rr = 0; m_valid = 0; m_rst = 0; m_err = 0; m_bin = 0; m_id = 0; m_ohc = '0;
    @(negedge clk);
    cycle(1);
    req_valid = '1;
    cycle(1);
    req_valid = '0;
    rst_n = 1'b1;

    // single requester: 7 + 6 = 2 (mod 11)
    set_req(0, 7, 6, 0); req_valid[0] = 1'b1;
    cycle(1);
    chk("t1_bin", 32'(res_bin), 32'd2);
    chk("t1_ohc", 32'(res_ohc), 32'b00000000100);
    cycle(1);

    // all requesters continuously valid after a fresh reset: ids 0,1,2,3,...
    rst_n = 1'b0; cycle(1); rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, i + 3, 2 * i, 0);
    req_valid = '1;
    for (int k = 0; k < 2 * NREQ; k++) begin
      cycle(0);
      chk("rr_order", 32'(res_id), 32'(k % NREQ));
    end
    req_valid = '0;
    cycle(1);

    // backpressure: pending result frozen, request 2 waits
    res_ready = 1'b0;
    set_req(0, 1, 2, 0); req_valid[0] = 1'b1;
    cycle(1);
    set_req(2, 10, 10, 0); req_valid[2] = 1'b1;
    for (int k = 0; k < 5; k++) cycle(1);
    res_ready = 1'b1;
    cycle(1);
    chk("t3_bin", 32'(res_bin), 32'd9);
    chk("t3_id", 32'(res_id), 32'd2);
    cycle(1);

    // illegal operand on requester 1; pointer must move to 2
    set_req(1, 12, 3, 0); req_valid[1] = 1'b1;
    cycle(1);
    chk("t4_err", 32'(res_err), 32'd1);
    chk("t4_bin", 32'(res_bin), 32'hF);
    chk("t4_ohc", 32'(res_ohc), 32'd0);
    set_req(0, 4, 4, 0); set_req(2, 5, 5, 0);
    req_valid = 4'b0101;
    cycle(1);
    chk("t4_next_id", 32'(res_id), 32'd2);
    cycle(1);

    // reset while a result is held; first grant then goes to lowest valid index
    res_ready = 1'b0;
    rst_n = 1'b0;
    cycle(1);
    rst_n = 1'b1; res_ready = 1'b1;
    set_req(1, 2, 2, 0); set_req(3, 9, 1, 0);
    req_valid = 4'b1010;
    cycle(1);
    chk("t5_id", 32'(res_id), 32'd1);
    cycle(1);
    cycle(1);

`ifdef OHC11_SUB_EN
    set_req(0, 3, 5, 1); req_valid[0] = 1'b1;
    cycle(1);
    chk("t6_bin", 32'(res_bin), 32'd9);
    chk("t6_ohc", 32'(res_ohc), 32'b01000000000);
    req_sub = '0;
`else
    set_req(0, 0, 0, 0); req_valid[0] = 1'b1;
    cycle(1);
    chk("t6_bin", 32'(res_bin), 32'd0);
    chk("t6_ohc", 32'(res_ohc), 32'b00000000001);
`endif
    cycle(1);

    // random traffic; operands only change on idle requesters
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom % 2 == 0)) begin
          set_req(i,
                  ($urandom % 8 == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10)),
                  ($urandom % 8 == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10)),
                  1'($urandom % 2));
          req_valid[i] = 1'b1;
        end
      end
      res_ready = ($urandom % 3 != 0);
      cycle(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
